hilo_unit: RTL and testbench
============================

// Module: hilo_unit
// PURPOSE
//  Owns the HI/LO architectural registers of the CPU and sequences the combinational 32x32 multiplier.
//  Latches operands on start and drives them to the multiplier for MUL_LAT cycles (multicycle path).
//  Then captures the 64-bit product into HI/LO. Also services MTHI/MTLO writes.
//  Drives busy so the pipeline stalls MFHI/MFLO until the product is committed.
// PARAMETERS
//  MUL_LAT  2  cycles operands are held before capture; legal 1..15
// PORTS
//  clk       in   1   system clock, rising edge
//  rst_n     in   1   asynchronous reset, active low
//  start     in   1   MULT/MULTU issue; accepted only when busy=0
//  sign_in   in   1   1=MULT (signed), 0=MULTU
//  acc_in    in   1   accumulate request (MADD); used only with HILO_MADD_EN
//  op_a      in   32  rs operand
//  op_b      in   32  rt operand
//  mul_a     out  32  registered operand A to multiplier
//  mul_b     out  32  registered operand B to multiplier
//  mul_sign  out  1   registered sign flag to multiplier
//  mul_hi    in   32  multiplier product [63:32]
//  mul_lo    in   32  multiplier product [31:0]
//  mthi      in   1   write wdata to HI
//  mtlo      in   1   write wdata to LO
//  wdata     in   32  MTHI/MTLO data
//  hi        out  32  HI register
//  lo        out  32  LO register
//  busy      out  1   1 while a multiply is in flight
//  done      out  1   one-cycle pulse in the cycle after HI/LO take the product
// BEHAVIOUR
//  - Clock is clk. Reset is rst_n: asynchronous and active low.
//  - Reset: hi=lo=0, mul_a=mul_b=0, mul_sign=0, busy=0, done=0, cnt=0, state=IDLE.
//    Reset mid-operation abandons the multiply. No done is issued and HI/LO are cleared.
//  - FSM states: IDLE, WAIT.
//  - IDLE: on start, latch op_a/op_b/sign_in (and acc_in) into mul_a/mul_b/mul_sign/acc_q.
//    Also set cnt=MUL_LAT-1, go to WAIT. busy rises the cycle after start.
//  - WAIT: busy=1; operands are held stable.
//    - cnt!=0: decrement cnt.
//    - cnt==0: on this edge hi<=mul_hi and lo<=mul_lo, state<=IDLE, done<=1 for the next cycle only.
//  - Latency: start at edge N leads to HI/LO updated at edge N+MUL_LAT, done high in cycle N+MUL_LAT.
//  - start while busy=1 is ignored (no queueing). The issuer must stall.
//  - start in the same cycle that WAIT completes is ignored; it is accepted the next cycle.
//  - MTHI/MTLO in IDLE: the register is written at the next edge. Both may assert in one cycle.
//  - MTHI/MTLO while busy: the write takes effect and the in-flight multiply is cancelled.
//    state<=IDLE, busy falls, no done, and that result is never written.
//  - MTHI/MTLO together with start in IDLE: the move writes, the start is accepted,
//    and the product later overwrites both registers.
//  - hi/lo change only on product capture, a move, or reset.
// CONFIGURATION
//  - HILO_MADD_EN defined: if acc_q=1, capture does {hi,lo}<={hi,lo}+{mul_hi,mul_lo}.
//    This is a 64-bit add with modulo 2^64 wrap, carry out discarded.
//  - HILO_MADD_EN undefined: acc_in is ignored; capture always overwrites.
// TESTING
//  - Reset mid-op: rst_n low during WAIT -> hi=lo=0, busy=0, done stays 0.
//  - MULTU: op_a=FFFFFFFF, op_b=2, sign_in=0 -> after MUL_LAT cycles hi=1, lo=FFFFFFFE, done pulses once.
//  - MULT: op_a=FFFFFFFF(-1), op_b=3, sign_in=1 -> hi=FFFFFFFF, lo=FFFFFFFD.
//  - Back-to-back: second start asserted while busy is ignored.
//    Re-asserted after done, 7*6 gives lo=0000002A, hi=0.
//  - Cancel: mthi with wdata=12345678 in WAIT -> hi=12345678, lo unchanged, busy=0 next cycle, no done.
//  - HILO_MADD_EN: hi=0, lo=FFFFFFFF, MADDU 1*1 -> hi=1, lo=0.
//    Without the macro the same stimulus gives hi=0, lo=1.

Source files
------------

// File: rtl/hilo_if.sv
// ---------------------------------------------------------------------------
// hilo_if -- bundle between the HI/LO unit and its surroundings
//
// Handshake: start is the request (valid) and !busy is the acceptance
// (ready). A start is consumed only on a rising edge where busy==0; while
// busy==1 the issuer must hold off, because a start seen then is dropped.
// done is a one-cycle pulse the cycle after HI/LO commit a product.
//
// Modports:
//   master : issuer + external multiplier (drives requests, moves, product)
//   slave  : hilo_unit (drives operands to multiplier, hi/lo, busy, done)
//
// Signals:
//   start, sign_in, acc_in, op_a, op_b : multiply issue
//   mul_a, mul_b, mul_sign             : registered operands to multiplier
//   mul_hi, mul_lo                     : combinational product back
//   mthi, mtlo, wdata                  : register moves
//   hi, lo, busy, done                 : architectural state / status
//   dbg_state                          : FSM state (0=IDLE, 1=WAIT)
// ---------------------------------------------------------------------------
interface hilo_if;
  logic        start;
  logic        sign_in;
  logic        acc_in;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_sign;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        dbg_state;

  modport master (
    output start, sign_in, acc_in, op_a, op_b,
    output mul_hi, mul_lo,
    output mthi, mtlo, wdata,
    input  mul_a, mul_b, mul_sign,
    input  hi, lo, busy, done, dbg_state
  );

  modport slave (
    input  start, sign_in, acc_in, op_a, op_b,
    input  mul_hi, mul_lo,
    input  mthi, mtlo, wdata,
    output mul_a, mul_b, mul_sign,
    output hi, lo, busy, done, dbg_state
  );
endinterface

// File: rtl/hilo_unit.sv
// ---------------------------------------------------------------------------
// hilo_unit -- HI/LO architectural registers and multicycle multiply sequencer
//
// On an accepted start the operands are registered onto mul_a/mul_b/mul_sign
// and held for MUL_LAT cycles while the external combinational multiplier
// settles (multicycle path), then mul_hi/mul_lo are captured into HI/LO.
// MTHI/MTLO write the registers directly; a move during a multiply cancels it.
//
// Parameters:
//   MUL_LAT : cycles operands are held before capture (1..15)
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : hilo_if.slave (see interface file for signal list)
//
// Optional feature: define HILO_MADD_EN to make a start with acc_in=1
// accumulate ({hi,lo} += product, modulo 2^64) instead of overwriting.
// ---------------------------------------------------------------------------
module hilo_unit #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  hilo_if.slave   bus
);

  localparam logic [3:0] LP_CNT_INIT = 4'(MUL_LAT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_mul_a;
  logic [31:0] r_mul_b;
  logic        r_mul_sign;
  logic        r_done;

  logic        w_move;
  logic        w_load;
  logic        w_capture;
  logic [31:0] w_cap_hi;
  logic [31:0] w_cap_lo;

  assign w_move = bus.mthi | bus.mtlo;

  // Next-state and control strobes. A move in WAIT wins over capture, so a
  // cancelled multiply never reaches HI/LO even if cnt has reached zero.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_move) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef HILO_MADD_EN
  logic        r_acc_q;
  logic [63:0] w_sum;

  // 64-bit accumulate; the carry out of bit 63 is dropped.
  assign w_sum = {r_hi, r_lo} + {bus.mul_hi, bus.mul_lo};
  assign {w_cap_hi, w_cap_lo} = r_acc_q ? w_sum : {bus.mul_hi, bus.mul_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_q <= 1'b0;
    end else if (w_load) begin
      r_acc_q <= bus.acc_in;
    end
  end
`else
  logic w_unused_acc;

  assign w_unused_acc = bus.acc_in;
  assign w_cap_hi     = bus.mul_hi;
  assign w_cap_lo     = bus.mul_lo;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand registers only change on acceptance, so they stay stable for
  // the whole WAIT window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a    <= 32'h0;
      r_mul_b    <= 32'h0;
      r_mul_sign <= 1'b0;
      r_cnt      <= 4'd0;
    end else begin
      if (w_load) begin
        r_mul_a    <= bus.op_a;
        r_mul_b    <= bus.op_b;
        r_mul_sign <= bus.sign_in;
        r_cnt      <= LP_CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Capture and moves never coincide (capture requires no move), so each
  // register has a single active writer per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi   <= 32'h0;
      r_lo   <= 32'h0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_capture;
      if (w_capture) begin
        r_hi <= w_cap_hi;
        r_lo <= w_cap_lo;
      end else begin
        if (bus.mthi) r_hi <= bus.wdata;
        if (bus.mtlo) r_lo <= bus.wdata;
      end
    end
  end

  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.mul_sign  = r_mul_sign;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.busy      = (r_state == S_WAIT);
  assign bus.done      = r_done;
  assign bus.dbg_state = (r_state == S_WAIT);

endmodule

// File: tb/tb_hilo_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_unit -- directed bench for hilo_unit (MUL_LAT=2)
// Inputs are driven and outputs sampled on the falling edge.
// The external multiplier is modelled combinationally from mul_a/mul_b.
// ---------------------------------------------------------------------------
module tb_hilo_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   done_seen;
  int   d0;

  hilo_if u_if ();

  hilo_unit #(.MUL_LAT(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  // ---- clock ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- external multiplier model ----
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  assign w_ext_a = u_if.mul_sign ? {{32{u_if.mul_a[31]}}, u_if.mul_a} : {32'h0, u_if.mul_a};
  assign w_ext_b = u_if.mul_sign ? {{32{u_if.mul_b[31]}}, u_if.mul_b} : {32'h0, u_if.mul_b};
  assign w_prod  = w_ext_a * w_ext_b;
  assign u_if.mul_hi = w_prod[63:32];
  assign u_if.mul_lo = w_prod[31:0];

  // ---- checker ----
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---- driver tasks ----
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    if (u_if.done) done_seen++;
  endtask

  // Presents a start for one edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic acc);
    u_if.start   = 1'b1;
    u_if.op_a    = a;
    u_if.op_b    = b;
    u_if.sign_in = s;
    u_if.acc_in  = acc;
    cycle();
    u_if.start   = 1'b0;
    u_if.acc_in  = 1'b0;
  endtask

  task automatic move(input logic h, input logic l, input logic [31:0] d);
    u_if.mthi  = h;
    u_if.mtlo  = l;
    u_if.wdata = d;
    cycle();
    u_if.mthi  = 1'b0;
    u_if.mtlo  = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    done_seen = 0;
    rst_n        = 1'b0;
    u_if.start   = 1'b0;
    u_if.sign_in = 1'b0;
    u_if.acc_in  = 1'b0;
    u_if.op_a    = 32'h0;
    u_if.op_b    = 32'h0;
    u_if.mthi    = 1'b0;
    u_if.mtlo    = 1'b0;
    u_if.wdata   = 32'h0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_hi",    u_if.hi, 64'h0);
    check("rst_lo",    u_if.lo, 64'h0);
    check("rst_busy",  u_if.busy, 64'h0);
    check("rst_done",  u_if.done, 64'h0);
    check("rst_mul_a", u_if.mul_a, 64'h0);
    check("rst_msign", u_if.mul_sign, 64'h0);
    check("rst_state", u_if.dbg_state, 64'h0);
    rst_n = 1'b1;
    cycle();

    // ---- MULTU FFFFFFFF*2 ----
    d0 = done_seen;
    issue(32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
    check("mu_busy1",  u_if.busy, 64'h1);
    check("mu_mul_a",  u_if.mul_a, 64'hFFFF_FFFF);
    check("mu_mul_b",  u_if.mul_b, 64'h2);
    check("mu_done1",  u_if.done, 64'h0);
    cycle();
    check("mu_busy2",  u_if.busy, 64'h1);
    check("mu_hi_early", u_if.hi, 64'h0);
    cycle();
    check("mu_hi",     u_if.hi, 64'h1);
    check("mu_lo",     u_if.lo, 64'hFFFF_FFFE);
    check("mu_done",   u_if.done, 64'h1);
    check("mu_busy3",  u_if.busy, 64'h0);
    cycle();
    check("mu_done_off", u_if.done, 64'h0);
    check("mu_pulses", done_seen - d0, 64'h1);

    // ---- MULT -1*3 and -2*-3 ----
    issue(32'hFFFF_FFFF, 32'h3, 1'b1, 1'b0);
    check("ms_sign", u_if.mul_sign, 64'h1);
    cycle(); cycle();
    check("ms_hi", u_if.hi, 64'hFFFF_FFFF);
    check("ms_lo", u_if.lo, 64'hFFFF_FFFD);
    issue(32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 1'b0);
    cycle(); cycle();
    check("ms2_hi", u_if.hi, 64'h0);
    check("ms2_lo", u_if.lo, 64'h6);

    // ---- back-to-back: starts while busy and at completion are dropped ----
    u_if.start = 1'b1; u_if.sign_in = 1'b0; u_if.op_a = 32'd5; u_if.op_b = 32'd5;
    cycle();
    u_if.op_a = 32'd7; u_if.op_b = 32'd6;
    cycle();
    check("bb_hold_a", u_if.mul_a, 64'd5);
    check("bb_hold_b", u_if.mul_b, 64'd5);
    u_if.op_a = 32'd9; u_if.op_b = 32'd9;
    cycle();
    check("bb_lo",   u_if.lo, 64'h19);
    check("bb_hi",   u_if.hi, 64'h0);
    check("bb_done", u_if.done, 64'h1);
    u_if.start = 1'b0;
    cycle();
    check("bb_ignored_busy", u_if.busy, 64'h0);
    check("bb_ignored_a",    u_if.mul_a, 64'd5);
    issue(32'd7, 32'd6, 1'b0, 1'b0);
    cycle(); cycle();
    check("bb2_lo", u_if.lo, 64'h2A);
    check("bb2_hi", u_if.hi, 64'h0);

    // ---- cancel by MTHI during WAIT ----
    d0 = done_seen;
    issue(32'd3, 32'd4, 1'b0, 1'b0);
    move(1'b1, 1'b0, 32'h1234_5678);
    check("cx_hi",   u_if.hi, 64'h1234_5678);
    check("cx_lo",   u_if.lo, 64'h2A);
    check("cx_busy", u_if.busy, 64'h0);
    cycle(); cycle();
    check("cx_lo_kept", u_if.lo, 64'h2A);
    check("cx_hi_kept", u_if.hi, 64'h1234_5678);
    check("cx_no_done", done_seen - d0, 64'h0);

    // ---- both moves in IDLE ----
    move(1'b1, 1'b1, 32'hCAFE_F00D);
    check("mv_hi", u_if.hi, 64'hCAFE_F00D);
    check("mv_lo", u_if.lo, 64'hCAFE_F00D);

    // ---- move together with start ----
    u_if.mtlo = 1'b1; u_if.wdata = 32'hAAAA_5555;
    issue(32'd2, 32'd3, 1'b0, 1'b0);
    u_if.mtlo = 1'b0;
    check("ms_mv_lo",   u_if.lo, 64'hAAAA_5555);
    check("ms_mv_hi",   u_if.hi, 64'hCAFE_F00D);
    check("ms_mv_busy", u_if.busy, 64'h1);
    cycle(); cycle();
    check("ms_prod_lo", u_if.lo, 64'h6);
    check("ms_prod_hi", u_if.hi, 64'h0);

    // ---- accumulate request ----
    move(1'b1, 1'b0, 32'h0);
    move(1'b0, 1'b1, 32'hFFFF_FFFF);
    issue(32'd1, 32'd1, 1'b0, 1'b1);
    cycle(); cycle();
`ifdef HILO_MADD_EN
    check("madd_hi", u_if.hi, 64'h1);
    check("madd_lo", u_if.lo, 64'h0);
`else
    check("madd_hi", u_if.hi, 64'h0);
    check("madd_lo", u_if.lo, 64'h1);
`endif
    move(1'b1, 1'b1, 32'hFFFF_FFFF);
    issue(32'd1, 32'd1, 1'b0, 1'b1);
    cycle(); cycle();
`ifdef HILO_MADD_EN
    check("madd_wrap_hi", u_if.hi, 64'h0);
    check("madd_wrap_lo", u_if.lo, 64'h0);
`else
    check("madd_wrap_hi", u_if.hi, 64'h0);
    check("madd_wrap_lo", u_if.lo, 64'h1);
`endif
    issue(32'd2, 32'd2, 1'b0, 1'b0);
    cycle(); cycle();
    check("plain_after_acc_hi", u_if.hi, 64'h0);
    check("plain_after_acc_lo", u_if.lo, 64'h4);

    // ---- reset mid-operation ----
    move(1'b1, 1'b1, 32'h5A5A_5A5A);
    d0 = done_seen;
    issue(32'd7, 32'd6, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rmid_hi",   u_if.hi, 64'h0);
    check("rmid_lo",   u_if.lo, 64'h0);
    check("rmid_busy", u_if.busy, 64'h0);
    check("rmid_mul_a", u_if.mul_a, 64'h0);
    @(negedge clk);
    cycle(); cycle();
    rst_n = 1'b1;
    cycle(); cycle();
    check("rmid_no_done", done_seen - d0, 64'h0);
    check("rmid_busy2",   u_if.busy, 64'h0);
    check("rmid_hi2",     u_if.hi, 64'h0);
    check("rmid_lo2",     u_if.lo, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time bound so a stuck run still ends with a report.
  initial begin
    #100000;
    n_errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
